egr_rrs_demux: RTL
==================

# egr_rrs_demux

Egress read-response demultiplexer: parametrised successor to the single-requestor read-response path between the Mesh Read Interface (MRI) and its consumers. It takes one unbackpressurable response stream from the MRI and steers each beat by client ID into one of N_CLIENTS per-client FIFOs. Each FIFO drains to its requestor through a valid/ready handshake. Per-client occupancy is exported for credit accounting, and overflow or bad-ID conditions are flagged as sticky errors.

## Interface
- N_CLIENTS, 4: number of requestor channels (1..16).
- DEPTH, 8: entries per client FIFO (power of 2, ≥2).
- DATA_W, 64: response data width.
- TAG_W, 8: response tag width; the tag is carried unchanged.
- CID_W, $clog2(N_CLIENTS) (min 1): client-ID width.
- cclk  in  1  sole clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- mri_rsp_valid  in  1  response beat present; there is no backpressure toward the MRI.
- mri_rsp_cid  in  CID_W  destination client.
- mri_rsp_tag  in  TAG_W  response tag.
- mri_rsp_data  in  DATA_W  response data.
- rsp_valid  out  N_CLIENTS  per-client head-entry valid.
- rsp_ready  in  N_CLIENTS  per-client consumer ready.
- rsp_tag  out  N_CLIENTS*TAG_W  per-client head tag; client i is at [i*TAG_W +: TAG_W].
- rsp_data  out  N_CLIENTS*DATA_W  per-client head data, packed the same way.
- occupancy  out  N_CLIENTS*($clog2(DEPTH)+1)  per-client entry count.
- overflow_err  out  N_CLIENTS  sticky per-client overflow flag.
- bad_cid_err  out  1  sticky flag: a beat arrived with cid ≥ N_CLIENTS.

## Operation
- Push: when mri_rsp_valid=1 and cid<N_CLIENTS, {tag,data} is written to FIFO[cid] at wr_ptr[cid]. wr_ptr[cid] increments modulo DEPTH and count[cid] increments.
- Pop: when rsp_valid[i] & rsp_ready[i], rd_ptr[i] increments modulo DEPTH and count[i] decrements. Pops on different clients are independent and may all occur in the same cycle.
- rsp_valid[i] = (count[i]≠0). rsp_tag and rsp_data present the entry at rd_ptr[i]. Once valid, the head is stable until it is popped.
- Simultaneous push and pop on the same client: both take effect and the count is unchanged. This holds when count=DEPTH and also when count=1.
- Full (count=DEPTH) with a push and no pop on that client: the beat is dropped, the FIFO is unchanged, and overflow_err[cid] is set.
- cid ≥ N_CLIENTS with valid: the beat is dropped, no FIFO changes, and bad_cid_err is set.
- Sticky errors clear only on rst.
- Order within a client is strict FIFO. No ordering is implied between clients.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Protocol: a requestor must not have more than DEPTH reads outstanding, tracked through occupancy plus its own in-flight count. Overflow is an error indication, not a flow-control mechanism.

## Timing
- Latency: a beat pushed in cycle t appears at rsp_valid/rsp_tag/rsp_data in cycle t+1 when the FIFO was empty. There is no combinational path from mri_rsp_* to rsp_*.
- A pop in cycle t shows the next head, or rsp_valid=0, in cycle t+1.
- occupancy is registered and reflects the pushes and pops of the previous cycle.
- rsp_ready→rsp_valid has no combinational dependency. rsp_valid must never depend on rsp_ready.
- Reset (rst=1 at an edge), values at the next edge:
  - all counts and pointers = 0;
  - rsp_valid=0, occupancy=0, overflow_err=0, bad_cid_err=0;
  - rsp_tag/rsp_data are don't-care while invalid; storage is not reset.
- Reset mid-operation discards all buffered entries. Beats presented while rst=1 are ignored.
- Throughput: 1 push/cycle in total and 1 pop/cycle per client.

## Test plan
- Single beat: N_CLIENTS=4. Send cid=2, tag=0x5A, data=0x1234 at t0 → rsp_valid=4'b0100 at t0+1 with tag 0x5A and data 0x1234. Hold rsp_ready=0 for 5 cycles → outputs stable. Pulse ready → valid=0 next cycle and occupancy[2]=0.
- Fill and overflow: DEPTH=8. Push 9 beats to cid=1 with tags 0..8 and ready=0 → occupancy[1]=8, overflow_err=4'b0010. Drain → tags 0..7 in order; tag 8 is absent.
- Full, push plus pop in the same cycle: fill cid=0 to 8. Push tag 0xAA while popping → no overflow, occupancy stays 8, and 0xAA is the last entry drained.
- Interleaved clients: round-robin pushes to cids 0..3, 4 each, with random per-client ready → each client receives its own tags in order, no cross-delivery, and all occupancies reach 0.
- Bad ID: N_CLIENTS=3 with cid=3 → bad_cid_err=1, all occupancies unchanged, and the flag persists until rst.
- Reset mid-stream: cid 0 and cid 3 at occupancy 5. Assert rst for 1 cycle → rsp_valid=0, occupancy=0, errors=0. A subsequent push delivers correctly.

Source files
------------

// File: rtl/egr_rrs_demux.sv
// ---------------------------------------------------------------------------
// egr_rrs_demux
//
// Egress read-response demultiplexer. Takes a single response stream from the
// Mesh Read Interface (no backpressure toward the MRI) and steers each beat by
// client ID into one of N_CLIENTS independent FIFOs. Each FIFO drains to its
// requestor through a valid/ready handshake.
//
// Ports
//   cclk            sole clock, rising edge
//   rst             synchronous, active-high reset
//   mri_rsp_valid   response beat present (cannot be stalled)
//   mri_rsp_cid     destination client
//   mri_rsp_tag     response tag (carried unchanged)
//   mri_rsp_data    response data
//   rsp_valid[i]    client i head entry valid
//   rsp_ready[i]    client i consumer ready
//   rsp_tag         client i head tag at [i*TAG_W +: TAG_W]
//   rsp_data        client i head data at [i*DATA_W +: DATA_W]
//   occupancy       client i entry count at [i*(log2(DEPTH)+1) +: log2(DEPTH)+1]
//   overflow_err[i] sticky: a beat for client i arrived while its FIFO was full
//   bad_cid_err     sticky: a beat arrived with cid >= N_CLIENTS
// ---------------------------------------------------------------------------
module egr_rrs_demux #(
  parameter int N_CLIENTS = 4,
  parameter int DEPTH     = 8,
  parameter int DATA_W    = 64,
  parameter int TAG_W     = 8,
  parameter int CID_W     = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
  input  logic                                     cclk,
  input  logic                                     rst,
  input  logic                                     mri_rsp_valid,
  input  logic [CID_W-1:0]                         mri_rsp_cid,
  input  logic [TAG_W-1:0]                         mri_rsp_tag,
  input  logic [DATA_W-1:0]                        mri_rsp_data,
  output logic [N_CLIENTS-1:0]                     rsp_valid,
  input  logic [N_CLIENTS-1:0]                     rsp_ready,
  output logic [N_CLIENTS*TAG_W-1:0]               rsp_tag,
  output logic [N_CLIENTS*DATA_W-1:0]              rsp_data,
  output logic [N_CLIENTS*($clog2(DEPTH)+1)-1:0]   occupancy,
  output logic [N_CLIENTS-1:0]                     overflow_err,
  output logic                                     bad_cid_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = TAG_W + DATA_W;

  // Compared as an int so a cid field wider than the client range is caught.
  logic cid_ok;
  assign cid_ok = (int'(mri_rsp_cid) < N_CLIENTS);

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge cclk) begin
    if (rst) begin
      bad_cid_err <= 1'b0;
    end else if (mri_rsp_valid && !cid_ok) begin
      bad_cid_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < N_CLIENTS; g++) begin : g_client
    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic             push;
    logic             pop;
    logic             full;
    logic             accept;
    logic [ENT_W-1:0] head;

    assign push = mri_rsp_valid && cid_ok && (mri_rsp_cid == CID_W'(g));
    assign full = (count == CNT_W'(DEPTH));
    // Valid comes only from the registered count, so ready never feeds valid.
    assign pop  = (count != '0) && rsp_ready[g];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign accept = push && (!full || pop);

    // NOTE: the entry storage has no reset; entries are only observable
    // through rsp_valid, which is driven from the reset count.
    always_ff @(posedge cclk) begin
      if (!rst && accept) begin
        mem[wr_ptr] <= {mri_rsp_tag, mri_rsp_data};
      end
    end

    always_ff @(posedge cclk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        ovf    <= 1'b0;
      end else begin
        if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
        case ({accept, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
        if (push && !accept) ovf <= 1'b1;
      end
    end

    assign head = mem[rd_ptr];

    assign rsp_valid[g]                    = (count != '0);
    assign rsp_tag[g*TAG_W +: TAG_W]       = head[ENT_W-1 -: TAG_W];
    assign rsp_data[g*DATA_W +: DATA_W]    = head[DATA_W-1:0];
    assign occupancy[g*CNT_W +: CNT_W]     = count;
    assign overflow_err[g]                 = ovf;
  end

endmodule
